inst_cache_dm_burst: RTL

//  Direct-mapped, read-only instruction cache with multi-word lines and burst refill from instruction RAM.

---
 rtl/inst_cache_dm_burst.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/inst_cache_dm_burst.sv
// Direct-mapped read-only instruction cache with multi-word lines.
// Lines are refilled word by word from the instruction RAM in address order.
// A line becomes valid only after its last word is stored. A flush clears
// every line and aborts any refill in progress.
module inst_cache_dm_burst #(
    parameter int unsigned LINES = 32,
    parameter int unsigned WORDS = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      address,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      out_data,
    output logic             miss,
    output logic             ram_read,
    output logic [31:0]      ram_addr,
    input  logic [31:0]      ram_data,
    input  logic             ram_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] refill_count
);

    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W - 2;
    // A single-word line still needs a 1-bit counter to keep widths legal.
    localparam int unsigned CNT_IW = (OFF_W > 0) ? OFF_W : 1;
    localparam int unsigned PTR_W  = IDX_W + CNT_IW;

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [31:0]        data_q [LINES*WORDS];

    logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic [CNT_IW-1:0]  cnt_q, cnt_d;
    logic               ram_read_q, ram_read_d;
    logic [31:0]        ram_addr_q, ram_addr_d;
    logic [CNT_W-1:0]   hit_count_q, refill_count_q;

    logic [TAG_W-1:0]   tag_w;
    logic [IDX_W-1:0]   idx_w;
    logic [CNT_IW-1:0]  word_w;
    logic [PTR_W-1:0]   rd_ptr_w, wr_ptr_w;
    logic               hit_w;
    logic               last_w;
    logic               word_we;
    logic               line_commit;

    // Split the fetch address and look up the addressed line.
    always_comb begin
        tag_w    = address[31 -: TAG_W];
        idx_w    = IDX_W'(address >> (OFF_W + 2));
        word_w   = CNT_IW'((address >> 2) & (WORDS - 1));
        rd_ptr_w = PTR_W'(32'(idx_w) * WORDS + 32'(word_w));
        wr_ptr_w = PTR_W'(32'(fill_idx_q) * WORDS + 32'(cnt_q));
        hit_w    = valid_q[idx_w] && (tag_q[idx_w] == tag_w) && (state_q == S_IDLE);
        last_w   = (32'(cnt_q) == WORDS - 1);
        miss     = !hit_w;
        out_data = (stall || !hit_w) ? '0 : data_q[rd_ptr_w];
    end

    // Next-state logic for the refill FSM and its bookkeeping registers.
    always_comb begin
        state_d     = state_q;
        fill_tag_d  = fill_tag_q;
        fill_idx_d  = fill_idx_q;
        cnt_d       = cnt_q;
        ram_read_d  = ram_read_q;
        ram_addr_d  = ram_addr_q;
        word_we     = 1'b0;
        line_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit_w && !flush) begin
                    state_d    = S_REFILL;
                    fill_tag_d = tag_w;
                    fill_idx_d = idx_w;
                    cnt_d      = '0;
                    ram_read_d = 1'b1;
                    ram_addr_d = address & ~32'(WORDS * 4 - 1);
                end
            end
            S_REFILL: begin
                // Flush wins over a word arriving in the same cycle.
                if (flush) begin
                    state_d    = S_IDLE;
                    ram_read_d = 1'b0;
                end else if (ram_ready) begin
                    word_we = 1'b1;
                    if (last_w) begin
                        line_commit = 1'b1;
                        ram_read_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        ram_addr_d = ram_addr_q + 32'd4;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state, refill tracking and performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            fill_tag_q     <= '0;
            fill_idx_q     <= '0;
            cnt_q          <= '0;
            ram_read_q     <= 1'b0;
            ram_addr_q     <= '0;
            hit_count_q    <= '0;
            refill_count_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            cnt_q      <= cnt_d;
            ram_read_q <= ram_read_d;
            ram_addr_q <= ram_addr_d;
            if (hit_w && !stall && !flush)
                hit_count_q <= hit_count_q + 1'b1;
            if (line_commit)
                refill_count_q <= refill_count_q + 1'b1;
        end
    end

    // Valid bits: cleared by flush, set once a whole line has been stored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            valid_q <= '0;
        else if (flush)
            valid_q <= '0;
        else if (line_commit)
            valid_q[fill_idx_q] <= 1'b1;
    end

    // Tag and data storage; contents are only observed through a valid line.
    always_ff @(posedge clock) begin
        if (word_we && !flush)
            data_q[wr_ptr_w] <= ram_data;
        if (line_commit)
            tag_q[fill_idx_q] <= fill_tag_q;
    end

    assign ram_read     = ram_read_q;
    assign ram_addr     = ram_addr_q;
    assign hit_count    = hit_count_q;
    assign refill_count = refill_count_q;

endmodule
